// File: rtl/divisor_restaurador.sv
// Unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero flagged with the result.
module divisor_restaurador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_num,
  input  logic [WIDTH-1:0] B_num,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t_sum;
  logic             no_borrow;
  logic [WIDTH:0]   r_full;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Trial subtract as R' + ~D + 1; carry out means R' >= D.
  always_comb begin
    r_sh = {r_reg, q_reg[WIDTH-1]};
    {no_borrow, t_sum} = {1'b0, r_sh}
                       + {1'b0, ~{1'b0, d_reg}}
                       + (WIDTH+2)'(1);
    r_full = no_borrow ? t_sum : r_sh;
    r_nxt  = WIDTH'(r_full);
    q_nxt  = {q_reg[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= A_num;
            d_reg <= B_num;
            r_reg <= '0;
            cnt   <= CW'(WIDTH-1);
            if (B_num == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= A_num;
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_restaurador.sv
// Self-checking bench for divisor_restaurador.
// Reference results come from plain / and % arithmetic.
module tb_divisor_restaurador;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A_num;
  logic [W-1:0] B_num;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq;
  logic [W-1:0] mr;
  logic         mdz;

  always #5 clk = ~clk;

  divisor_restaurador #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A_num    (A_num),
    .B_num    (B_num),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (b == 0) begin
      mq  = '1;
      mr  = a;
      mdz = 1'b1;
    end else begin
      mq  = a / b;
      mr  = a % b;
      mdz = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A_num = '0;
    B_num = '0;
    repeat (3) step();
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    mq = '0; mr = '0; mdz = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  // One division from IDLE; checks busy/done timing, hold and result.
  task automatic do_div(input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n;
    logic eb, ed;
    start = 1'b1;
    A_num = a;
    B_num = b;
    step();
    start = 1'b0;
    A_num = W'($urandom);
    B_num = W'($urandom);
    n = (b == 0) ? 1 : W + 1;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) step();
      eb = (b != 0) && (i <= W);
      ed = (i == n);
      checks++;
      if (busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL timing %0d/%0d cyc%0d: busy=%b done=%b want %b %b",
                 a, b, i, busy, done, eb, ed);
      end
      if (i < n) begin
        checks++;
        if (quotient !== mq || remainder !== mr || div_zero !== mdz) begin
          errors++;
          $display("FAIL hold %0d/%0d: q=%0d r=%0d z=%b want %0d %0d %b",
                   a, b, quotient, remainder, div_zero, mq, mr, mdz);
        end
      end
    end
    model(a, b);
    checks++;
    if (quotient !== mq || remainder !== mr || div_zero !== mdz) begin
      errors++;
      $display("FAIL result %0d/%0d: q=%0d r=%0d z=%b want %0d %0d %b",
               a, b, quotient, remainder, div_zero, mq, mr, mdz);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse %0d/%0d: done=%b busy=%b want 0 0",
               a, b, done, busy);
    end
  endtask

  task automatic test_directed();
    do_div(4'd11, 4'd3);
    do_div(4'd15, 4'd15);
    do_div(4'd15, 4'd1);
    do_div(4'd5,  4'd6);
    do_div(4'd7,  4'd0);
    do_div(4'd0,  4'd9);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_div(W'($urandom), W'($urandom_range(0, 15)));
  endtask

  task automatic test_ignore_start();
    start = 1'b1;
    A_num = 4'd11;
    B_num = 4'd3;
    step();
    start = 1'b0;
    for (int i = 1; i <= W + 1; i++) begin
      if (i > 1) step();
      if (i == 2) begin
        start = 1'b1;
        A_num = 4'd9;
        B_num = 4'd2;
      end else begin
        start = 1'b0;
      end
    end
    model(4'd11, 4'd3);
    checks++;
    if (done !== 1'b1 || quotient !== mq || remainder !== mr) begin
      errors++;
      $display("FAIL ignore: done=%b q=%0d r=%0d want 1 %0d %0d",
               done, quotient, remainder, mq, mr);
    end
    repeat (3) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL not_queued: busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    start = 1'b1;
    A_num = 4'd13;
    B_num = 4'd4;
    step();
    start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    mq = '0; mr = '0; mdz = 1'b0;
    seen = 1'b0;
    repeat (2 * W + 2) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort: activity after reset got 1 want 0");
    end
  endtask

  // All 256 pairs with start held high; period between dones is checked.
  task automatic test_back_to_back();
    logic [7:0] idx;
    logic [W-1:0] a, b;
    int cnt, want;
    idx = 8'd0;
    start = 1'b1;
    A_num = idx[7:4];
    B_num = idx[3:0];
    for (int p = 0; p < 256; p++) begin
      idx = 8'(p);
      a = idx[7:4];
      b = idx[3:0];
      want = ((b == 0) ? 1 : W + 1) + ((p > 0) ? 1 : 0);
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (done !== 1'b1 && cnt < 2 * W + 6);
      model(a, b);
      checks++;
      if (cnt !== want || quotient !== mq ||
          remainder !== mr || div_zero !== mdz) begin
        errors++;
        $display("FAIL b2b %0d/%0d: cyc=%0d q=%0d r=%0d z=%b want %0d %0d %0d %b",
                 a, b, cnt, quotient, remainder, div_zero,
                 want, mq, mr, mdz);
      end
      if (p < 255) begin
        idx = 8'(p + 1);
        A_num = idx[7:4];
        B_num = idx[3:0];
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: done=%b want 0", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_reset_mid();
    do_div(4'd11, 4'd3);
    test_back_to_back();
    do_div(4'd14, 4'd5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
